// File: rtl/pe_ws_db.sv
// pe_ws_db: weight-stationary MAC processing element with a double-buffered (shadow/active) weight.
// Define PE_PSUM_SAT_EN to saturate the accumulate; otherwise it wraps modulo 2^PSUM_W.
module pe_ws_db #(
  parameter int ACT_W  = 8,
  parameter int WGT_W  = 8,
  parameter int PSUM_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_load,
  input  logic [WGT_W-1:0]  w_in,
  input  logic              w_swap,
  input  logic [ACT_W-1:0]  act_in,
  input  logic              act_valid_in,
  input  logic [PSUM_W-1:0] psum_in,
  output logic [ACT_W-1:0]  act_out,
  output logic              act_valid_out,
  output logic [PSUM_W-1:0] psum_out,
  output logic              w_active_vld,
  output logic [CNT_W-1:0]  mac_cnt
);
  localparam int PW = ACT_W + WGT_W;
  typedef enum logic [1:0] {EMPTY, SH_ONLY, ACT, ACT_SH} state_t;
  state_t            r_state;
  logic [WGT_W-1:0]  r_wgt, r_sh;
  logic [ACT_W-1:0]  r_act;
  logic              r_vld;
  logic [PSUM_W-1:0] r_psum;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_has_act, w_has_sh, w_swap_eff, w_mac, w_act_nxt, w_sh_nxt;
  logic [PW-1:0]     w_prod;
  logic [PSUM_W-1:0] w_acc;
  assign w_has_act  = (r_state == ACT) || (r_state == ACT_SH);
  assign w_has_sh   = (r_state == SH_ONLY) || (r_state == ACT_SH);
  assign w_swap_eff = w_swap && w_has_sh;
  assign w_mac      = act_valid_in && w_has_act;
  assign w_act_nxt  = w_has_act || w_swap_eff;
  assign w_sh_nxt   = w_load || (w_has_sh && !w_swap_eff);
  // Both operands sign-extended to the full product width, so the low PW bits are the signed product.
  assign w_prod = {{WGT_W{act_in[ACT_W-1]}}, act_in} * {{ACT_W{r_wgt[WGT_W-1]}}, r_wgt};
`ifdef PE_PSUM_SAT_EN
  logic [PSUM_W:0] w_sum;
  assign w_sum = {{(PSUM_W+1-PW){w_prod[PW-1]}}, w_prod} + {psum_in[PSUM_W-1], psum_in};
  assign w_acc = (w_sum[PSUM_W] == w_sum[PSUM_W-1]) ? w_sum[PSUM_W-1:0]
               : {w_sum[PSUM_W], {(PSUM_W-1){~w_sum[PSUM_W]}}};
`else
  assign w_acc = {{(PSUM_W-PW){w_prod[PW-1]}}, w_prod} + psum_in;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= EMPTY;
      r_wgt   <= '0;
      r_sh    <= '0;
      r_act   <= '0;
      r_vld   <= 1'b0;
      r_psum  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_act_nxt ? (w_sh_nxt ? ACT_SH : ACT) : (w_sh_nxt ? SH_ONLY : EMPTY);
      if (w_swap_eff) r_wgt <= r_sh;
      if (w_load) r_sh <= w_in;
      if (act_valid_in) r_act <= act_in;
      if (act_valid_in) r_psum <= w_has_act ? w_acc : psum_in;
      r_vld <= act_valid_in;
      if (w_swap_eff) r_cnt <= '0;
      else if (w_mac && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  assign act_out       = r_act;
  assign act_valid_out = r_vld;
  assign psum_out      = r_psum;
  assign w_active_vld  = w_has_act;
  assign mac_cnt       = r_cnt;
endmodule

// File: tb/tb_pe_ws_db.sv
// tb_pe_ws_db: directed vector table plus randomized traffic against a queue-based reference model.
module tb_pe_ws_db;
  logic        clk = 1'b0;
  logic        rst_n, w_load, w_swap, act_valid_in;
  logic [7:0]  w_in, act_in;
  logic [31:0] psum_in;
  logic [7:0]  act_out, act_out2;
  logic        act_valid_out, act_valid_out2, w_active_vld, w_active_vld2;
  logic [31:0] psum_out, psum_out2;
  logic [15:0] mac_cnt;
  logic [1:0]  mac_cnt2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pe_ws_db u_dut (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum_in),
    .act_out(act_out), .act_valid_out(act_valid_out), .psum_out(psum_out),
    .w_active_vld(w_active_vld), .mac_cnt(mac_cnt)
  );

  pe_ws_db #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum_in),
    .act_out(act_out2), .act_valid_out(act_valid_out2), .psum_out(psum_out2),
    .w_active_vld(w_active_vld2), .mac_cnt(mac_cnt2)
  );

  // Reference model: shadow held as a 0/1-entry queue.
  int m_sh[$];
  int m_wgt, m_psum, m_act, m_cnt;
  bit m_has_act, m_vld;

  function automatic int acc(int w, int a, int p);
    longint s;
    logic [63:0] b;
    s = longint'(w) * longint'(a) + longint'(p);
`ifdef PE_PSUM_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    b = s;
    return int'(b[31:0]);
  endfunction

  task automatic model_step(input bit rn, ld, input int wi, input bit sw, input int a, input bit v, input int p);
    if (!rn) begin
      m_sh.delete();
      m_wgt = 0; m_psum = 0; m_act = 0; m_cnt = 0; m_has_act = 0; m_vld = 0;
    end else begin
      if (v) begin
        m_act = a;
        m_psum = m_has_act ? acc(m_wgt, a, p) : p;
        if (m_has_act) m_cnt++;
      end
      m_vld = v;
      if (sw && m_sh.size() > 0) begin
        m_wgt = m_sh.pop_front();
        m_has_act = 1;
        m_cnt = 0;
      end
      if (ld) begin
        m_sh.delete();
        m_sh.push_back(wi);
      end
    end
  endtask

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic cyc(input bit rn, ld, input int wi, input bit sw, input int a, input bit v, input int p);
    rst_n = rn; w_load = ld; w_in = 8'(wi); w_swap = sw;
    act_in = 8'(a); act_valid_in = v; psum_in = p;
    @(posedge clk);
    #1;
    model_step(rn, ld, wi, sw, a, v, p);
    chk("m_psum", longint'($signed(psum_out)), m_psum);
    chk("m_act", longint'($signed(act_out)), m_act);
    chk("m_vld", act_valid_out, m_vld);
    chk("m_wv", w_active_vld, m_has_act);
    chk("m_cnt", mac_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("m_cnt2", mac_cnt2, (m_cnt > 3) ? 3 : m_cnt);
    chk("m_psum2", longint'($signed(psum_out2)), m_psum);
  endtask

  typedef struct {
    bit rn, ld; int wi; bit sw; int a; bit v; int p;
    int e_psum, e_act; bit e_vld, e_wv; int e_cnt, e_cnt2;
  } vec_t;
  vec_t tbl[23];

  initial begin
    int sat_hi, sat_lo, min32, p;
    min32 = int'(32'h8000_0000);
`ifdef PE_PSUM_SAT_EN
    sat_hi = 2147483647;
    sat_lo = min32;
`else
    sat_hi = -2147467619;
    sat_lo = 2147467392;
`endif
    tbl[0]  = '{0,0,0,  0,0,   0,0,          0,   0,   0,0,0,0};
    tbl[1]  = '{1,1,3,  0,0,   0,0,          0,   0,   0,0,0,0};
    tbl[2]  = '{1,0,0,  1,0,   0,0,          0,   0,   0,1,0,0};
    tbl[3]  = '{1,0,0,  0,-4,  1,10,         -2,  -4,  1,1,1,1};
    tbl[4]  = '{1,1,5,  0,0,   0,0,          -2,  -4,  0,1,1,1};
    tbl[5]  = '{1,1,7,  1,2,   1,0,          6,   2,   1,1,0,0};
    tbl[6]  = '{1,0,0,  0,2,   1,0,          10,  2,   1,1,1,1};
    tbl[7]  = '{1,0,0,  0,1,   1,0,          5,   1,   1,1,2,2};
    tbl[8]  = '{1,0,0,  0,1,   1,0,          5,   1,   1,1,3,3};
    tbl[9]  = '{1,0,0,  0,1,   1,0,          5,   1,   1,1,4,3};
    tbl[10] = '{1,0,0,  0,1,   1,0,          5,   1,   1,1,5,3};
    tbl[11] = '{1,0,0,  1,0,   0,0,          5,   1,   0,1,0,0};
    tbl[12] = '{1,0,0,  0,3,   1,1,          22,  3,   1,1,1,1};
    tbl[13] = '{1,0,0,  1,0,   0,0,          22,  3,   0,1,1,1};
    tbl[14] = '{1,0,0,  0,-1,  1,0,          -7,  -1,  1,1,2,2};
    tbl[15] = '{1,1,9,  0,0,   0,0,          -7,  -1,  0,1,2,2};
    tbl[16] = '{0,1,1,  1,5,   1,50,         0,   0,   0,0,0,0};
    tbl[17] = '{1,0,0,  1,0,   0,0,          0,   0,   0,0,0,0};
    tbl[18] = '{1,0,0,  0,9,   1,100,        100, 9,   1,0,0,0};
    tbl[19] = '{1,1,127,0,0,   0,0,          100, 9,   0,0,0,0};
    tbl[20] = '{1,0,0,  1,0,   0,0,          100, 9,   0,1,0,0};
    tbl[21] = '{1,0,0,  0,127, 1,2147483548, sat_hi, 127,  1,1,1,1};
    tbl[22] = '{1,0,0,  0,-128,1,min32,      sat_lo, -128, 1,1,2,2};
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].rn, tbl[i].ld, tbl[i].wi, tbl[i].sw, tbl[i].a, tbl[i].v, tbl[i].p);
      chk($sformatf("row%0d psum", i), longint'($signed(psum_out)), tbl[i].e_psum);
      chk($sformatf("row%0d act", i), longint'($signed(act_out)), tbl[i].e_act);
      chk($sformatf("row%0d vld", i), act_valid_out, tbl[i].e_vld);
      chk($sformatf("row%0d wv", i), w_active_vld, tbl[i].e_wv);
      chk($sformatf("row%0d cnt", i), mac_cnt, tbl[i].e_cnt);
      chk($sformatf("row%0d cnt2", i), mac_cnt2, tbl[i].e_cnt2);
    end
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       p = 2147483647 - int'($urandom_range(0, 20000));
        1:       p = min32 + int'($urandom_range(0, 20000));
        default: p = int'($urandom_range(0, 2000)) - 1000;
      endcase
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)) - 128,
          $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)) - 128, $urandom_range(0, 3) != 0, p);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
